// File: rtl/shifter_arbiter_if.sv
// rtl/shifter_arbiter_if.sv - requester/shifter signal bundle for shifter_arbiter
interface shifter_arbiter_if;
  logic        req0;
  logic        req1;
  logic [31:0] dataA0;
  logic [31:0] dataA1;
  logic [31:0] dataB0;
  logic [31:0] dataB1;
  logic [5:0]  Signal0;
  logic [5:0]  Signal1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [31:0] shA;
  logic [31:0] shB;
  logic [5:0]  shSignal;
  logic [31:0] shOut;
  logic [31:0] dataOut;
  logic        busy;

  // arbiter side
  modport slave (
    input  req0, req1, dataA0, dataA1, dataB0, dataB1, Signal0, Signal1, shOut,
    output gnt0, gnt1, done0, done1, shA, shB, shSignal, dataOut, busy
  );

  // requester/shifter side
  modport master (
    output req0, req1, dataA0, dataA1, dataB0, dataB1, Signal0, Signal1, shOut,
    input  gnt0, gnt1, done0, done1, shA, shB, shSignal, dataOut, busy
  );
endinterface

// File: rtl/shifter_arbiter.sv
// rtl/shifter_arbiter.sv - two-requester arbiter for one shared barrel shifter; SHIFTER_ARB_RR_EN enables round-robin
module shifter_arbiter #(
  parameter int SHIFT_LAT = 1
) (
  input logic              clk,
  input logic              reset,
  shifter_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SHIFT_LAT - 1);

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic        owner;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [5:0]  op_sig;
  logic [31:0] data_out;
  logic        gnt0_q;
  logic        gnt1_q;
  logic        done0_q;
  logic        done1_q;
  logic        busy_q;
  logic        pick;
  logic        take;
  logic        cap;

`ifdef SHIFTER_ARB_RR_EN
  logic        ptr;

  // winner: favoured requester on a tie, otherwise whoever is asking
  always_comb begin
    pick = 1'b0;
    if (bus.req0 && bus.req1) pick = ptr;
    else                      pick = bus.req1;
  end

  // pointer moves to the loser after every grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     ptr <= 1'b0;
    else if (take) ptr <= ~pick;
  end
`else
  // winner: requester 0 always wins when it asks
  always_comb begin
    pick = 1'b0;
    pick = ~bus.req0;
  end
`endif

  // next-state logic; requests only looked at in IDLE
  always_comb begin
    state_n = state;
    take    = 1'b0;
    cap     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_n = BUSY;
          take    = 1'b1;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_n = DONE;
          cap     = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // handshake pulses, operand latch, latency counter and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      cnt      <= 4'd0;
      owner    <= 1'b0;
      op_a     <= 32'd0;
      op_b     <= 32'd0;
      op_sig   <= 6'd0;
      data_out <= 32'd0;
    end else begin
      gnt0_q  <= take & ~pick;
      gnt1_q  <= take & pick;
      done0_q <= cap & ~owner;
      done1_q <= cap & owner;
      busy_q  <= (state_n != IDLE);
      if (take) begin
        owner  <= pick;
        cnt    <= CNT_LOAD;
        op_a   <= pick ? bus.dataA1  : bus.dataA0;
        op_b   <= pick ? bus.dataB1  : bus.dataB0;
        op_sig <= pick ? bus.Signal1 : bus.Signal0;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (cap) data_out <= bus.shOut;
    end
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.busy     = busy_q;
  assign bus.dataOut  = data_out;
  assign bus.shA      = op_a;
  assign bus.shB      = op_b;
  assign bus.shSignal = op_sig;

endmodule

// File: tb/tb_shifter_arbiter.sv
// tb/tb_shifter_arbiter.sv - scoreboard bench for shifter_arbiter at SHIFT_LAT 1 and 3
module tb_shifter_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  shifter_arbiter_if b1();
  shifter_arbiter_if b3();

  assign b1.shOut = b1.shA << b1.shB[4:0];
  assign b3.shOut = b3.shA << b3.shB[4:0];

  shifter_arbiter #(.SHIFT_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  shifter_arbiter #(.SHIFT_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    b1.req0 = 0; b1.req1 = 0; b1.dataA0 = 0; b1.dataA1 = 0;
    b1.dataB0 = 0; b1.dataB1 = 0; b1.Signal0 = 0; b1.Signal1 = 0;
    b3.req0 = 0; b3.req1 = 0; b3.dataA0 = 0; b3.dataA1 = 0;
    b3.dataB0 = 0; b3.dataB1 = 0; b3.Signal0 = 0; b3.Signal1 = 0;
  endtask

  task automatic wait_gnt(input bit use3, output int who, output int cyc);
    logic g0, g1;
    who = -1;
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      g0 = use3 ? b3.gnt0 : b1.gnt0;
      g1 = use3 ? b3.gnt1 : b1.gnt1;
      if (g0 || g1) begin
        who = (g0 && g1) ? 2 : (g1 ? 1 : 0);
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_done(input bit use3, output int who, output int cyc);
    logic d0, d1;
    who = -1;
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      d0 = use3 ? b3.done0 : b1.done0;
      d1 = use3 ? b3.done1 : b1.done1;
      if (d0 || d1) begin
        who = (d0 && d1) ? 2 : (d1 ? 1 : 0);
        cyc = i;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    repeat (3) @(negedge clk);
    total++; if ({b1.gnt0, b1.gnt1, b1.done0, b1.done1, b1.busy} !== 5'd0) begin bad++; $display("FAIL reset_flags1: got %b want 00000", {b1.gnt0, b1.gnt1, b1.done0, b1.done1, b1.busy}); end
    total++; if ({b3.gnt0, b3.gnt1, b3.done0, b3.done1, b3.busy} !== 5'd0) begin bad++; $display("FAIL reset_flags3: got %b want 00000", {b3.gnt0, b3.gnt1, b3.done0, b3.done1, b3.busy}); end
    total++; if (b1.dataOut !== 32'd0) begin bad++; $display("FAIL reset_dataOut: got %h want 0", b1.dataOut); end
    total++; if ({b1.shA, b1.shB, b1.shSignal} !== 70'd0) begin bad++; $display("FAIL reset_sh: got %h %h %h want 0", b1.shA, b1.shB, b1.shSignal); end
    reset = 0;
    repeat (2) @(negedge clk);
    total++; if (b1.busy !== 1'b0 || b1.gnt0 !== 1'b0) begin bad++; $display("FAIL idle_no_req: busy=%b gnt0=%b want 0 0", b1.busy, b1.gnt0); end
  endtask

  task automatic test_single();
    int who, cyc;
    logic [32:0] e;
    b1.dataA0 = 32'h1; b1.dataB0 = 32'd5; b1.Signal0 = 6'h2a; b1.req0 = 1;
    sb.push_back({1'b0, 32'h0000_0020});
    wait_gnt(0, who, cyc);
    total++; if (who !== 0 || cyc !== 1) begin bad++; $display("FAIL single_gnt: who=%0d cyc=%0d want 0 1", who, cyc); end
    b1.req0 = 0;
    total++; if (b1.busy !== 1'b1 || b1.shSignal !== 6'h2a || b1.shA !== 32'h1) begin bad++; $display("FAIL single_busy: busy=%b sig=%h shA=%h want 1 2a 1", b1.busy, b1.shSignal, b1.shA); end
    wait_done(0, who, cyc);
    total++; if (who !== 0 || cyc !== 1) begin bad++; $display("FAIL single_done: who=%0d cyc=%0d want 0 1", who, cyc); end
    e = (sb.size() > 0) ? sb.pop_front() : 33'h1_dead_beef;
    total++; if (b1.dataOut !== e[31:0]) begin bad++; $display("FAIL single_data: got %h want %h", b1.dataOut, e[31:0]); end
    @(negedge clk);
    total++; if (b1.busy !== 1'b0 || b1.done0 !== 1'b0 || b1.done1 !== 1'b0) begin bad++; $display("FAIL single_after: busy=%b done0=%b done1=%b want 0 0 0", b1.busy, b1.done0, b1.done1); end
  endtask

  task automatic test_masking();
    int who, cyc;
    logic [32:0] e;
    logic [31:0] a_tab[2];
    logic [31:0] b_tab[2];
    logic [31:0] r_tab[2];
    a_tab[0] = 32'h0000_000F; b_tab[0] = 32'hFFFF_FFE3; r_tab[0] = 32'h0000_0078;
    a_tab[1] = 32'h0000_0003; b_tab[1] = 32'd31;        r_tab[1] = 32'h8000_0000;
    for (int k = 0; k < 2; k++) begin
      b1.dataA1 = a_tab[k]; b1.dataB1 = b_tab[k]; b1.Signal1 = 6'h07; b1.req1 = 1;
      sb.push_back({1'b1, r_tab[k]});
      wait_gnt(0, who, cyc);
      total++; if (who !== 1 || cyc !== 1) begin bad++; $display("FAIL mask_gnt%0d: who=%0d cyc=%0d want 1 1", k, who, cyc); end
      b1.req1 = 0;
      wait_done(0, who, cyc);
      e = (sb.size() > 0) ? sb.pop_front() : 33'h0_dead_beef;
      total++; if (who !== int'(e[32])) begin bad++; $display("FAIL mask_owner%0d: got %0d want %0d", k, who, e[32]); end
      total++; if (b1.dataOut !== e[31:0]) begin bad++; $display("FAIL mask_data%0d: got %h want %h", k, b1.dataOut, e[31:0]); end
      @(negedge clk);
    end
  endtask

  task automatic test_arbitration();
    int who, cyc;
    logic [32:0] e;
    int exp_who[3];
`ifdef SHIFTER_ARB_RR_EN
    exp_who[0] = 0; exp_who[1] = 1; exp_who[2] = 0;
`else
    exp_who[0] = 0; exp_who[1] = 0; exp_who[2] = 0;
`endif
    pulse_reset();
    b1.dataA0 = 32'h11;  b1.dataB0 = 32'd2; b1.Signal0 = 6'h05;
    b1.dataA1 = 32'h101; b1.dataB1 = 32'd8; b1.Signal1 = 6'h3a;
    b1.req0 = 1; b1.req1 = 1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back(exp_who[k] == 1 ? {1'b1, 32'h0001_0100} : {1'b0, 32'h0000_0044});
      wait_gnt(0, who, cyc);
      total++; if (who !== exp_who[k]) begin bad++; $display("FAIL arb_gnt%0d: who=%0d want %0d", k, who, exp_who[k]); end
      total++; if (b1.shSignal !== (exp_who[k] == 1 ? 6'h3a : 6'h05)) begin bad++; $display("FAIL arb_sig%0d: got %h", k, b1.shSignal); end
      wait_done(0, who, cyc);
      e = (sb.size() > 0) ? sb.pop_front() : 33'h0_dead_beef;
      total++; if (who !== int'(e[32]) || b1.dataOut !== e[31:0]) begin bad++; $display("FAIL arb_done%0d: who=%0d data=%h want %0d %h", k, who, b1.dataOut, e[32], e[31:0]); end
    end
    b1.req0 = 0; b1.req1 = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_latency3();
    int who, cyc, done_at;
    logic [32:0] e;
    b3.dataA0 = 32'hA5A5_A5A5; b3.dataB0 = 32'd4; b3.Signal0 = 6'h11; b3.req0 = 1;
    sb.push_back({1'b0, 32'h5A5A_5A50});
    wait_gnt(1, who, cyc);
    total++; if (who !== 0 || cyc !== 1) begin bad++; $display("FAIL lat3_gnt: who=%0d cyc=%0d want 0 1", who, cyc); end
    b3.dataA0 = 32'hFFFF_0000; b3.req0 = 0;
    done_at = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (b3.done0 || b3.done1) begin done_at = i; break; end
      total++; if (b3.shA !== 32'hA5A5_A5A5 || b3.busy !== 1'b1) begin bad++; $display("FAIL lat3_hold: shA=%h busy=%b want a5a5a5a5 1", b3.shA, b3.busy); end
    end
    total++; if (done_at !== 3 || b3.done0 !== 1'b1) begin bad++; $display("FAIL lat3_done: at=%0d done0=%b want 3 1", done_at, b3.done0); end
    e = (sb.size() > 0) ? sb.pop_front() : 33'h0_dead_beef;
    total++; if (b3.dataOut !== e[31:0]) begin bad++; $display("FAIL lat3_data: got %h want %h", b3.dataOut, e[31:0]); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_busy();
    int who, cyc;
    bit saw_done;
    logic [32:0] e;
    b3.dataA0 = 32'h1; b3.dataB0 = 32'd1; b3.req0 = 1;
    wait_gnt(1, who, cyc);
    total++; if (who !== 0) begin bad++; $display("FAIL rb_gnt0: who=%0d want 0", who); end
    b3.req0 = 0;
    @(negedge clk);
    #2 reset = 1;
    #1;
    total++; if ({b3.gnt0, b3.gnt1, b3.done0, b3.done1, b3.busy} !== 5'd0) begin bad++; $display("FAIL rb_async_flags: got %b want 00000", {b3.gnt0, b3.gnt1, b3.done0, b3.done1, b3.busy}); end
    total++; if (b3.dataOut !== 32'd0 || b3.shA !== 32'd0 || b3.shB !== 32'd0) begin bad++; $display("FAIL rb_async_data: dataOut=%h shA=%h shB=%h want 0", b3.dataOut, b3.shA, b3.shB); end
    b3.dataA1 = 32'h9; b3.dataB1 = 32'd3; b3.Signal1 = 6'h01; b3.req1 = 1;
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (b3.done0 || b3.done1) saw_done = 1;
    end
    reset = 0;
    sb.push_back({1'b1, 32'h0000_0048});
    wait_gnt(1, who, cyc);
    total++; if (who !== 1 || cyc !== 1) begin bad++; $display("FAIL rb_gnt1: who=%0d cyc=%0d want 1 1", who, cyc); end
    b3.req1 = 0;
    wait_done(1, who, cyc);
    e = (sb.size() > 0) ? sb.pop_front() : 33'h0_dead_beef;
    total++; if (who !== int'(e[32]) || cyc !== 3 || b3.dataOut !== e[31:0]) begin bad++; $display("FAIL rb_done: who=%0d cyc=%0d data=%h want %0d 3 %h", who, cyc, b3.dataOut, e[32], e[31:0]); end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL rb_no_done: saw=%b want 0", saw_done); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int grants, dones, prev_g;
    logic [31:0] last;
    logic [31:0] nxt;
    logic [32:0] e;
    pulse_reset();
    last = 32'd0;
    grants = 0; dones = 0; prev_g = -1;
    b1.dataA0 = 32'h7; b1.dataB0 = 32'd0; b1.Signal0 = 6'h01; b1.req0 = 1;
    sb.push_back({1'b0, 32'h7});
    for (int i = 1; i <= 60 && dones < 4; i++) begin
      @(negedge clk);
      total++; if (b1.gnt1 !== 1'b0 || b1.done1 !== 1'b0) begin bad++; $display("FAIL b2b_side1: gnt1=%b done1=%b want 0 0", b1.gnt1, b1.done1); end
      if (b1.gnt0) begin
        if (prev_g >= 0) begin
          total++; if (i - prev_g !== 3) begin bad++; $display("FAIL b2b_period: got %0d want 3", i - prev_g); end
        end
        prev_g = i;
        grants++;
        if (grants < 4) begin
          b1.dataB0 = 32'(grants);
          nxt = 32'h7 << grants;
          sb.push_back({1'b0, nxt});
        end else begin
          b1.req0 = 0;
        end
      end
      if (b1.done0) begin
        e = (sb.size() > 0) ? sb.pop_front() : 33'h0_dead_beef;
        total++; if (b1.dataOut !== e[31:0]) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", dones, b1.dataOut, e[31:0]); end
        last = e[31:0];
        dones++;
      end else begin
        total++; if (b1.dataOut !== last) begin bad++; $display("FAIL b2b_stable: got %h want %h", b1.dataOut, last); end
      end
    end
    total++; if (dones !== 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", dones); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_masking();
    test_arbitration();
    test_latency3();
    test_reset_busy();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
